// File: rtl/matrix_pop_sequencer.sv
// matrix_pop_sequencer: drains a matrix row by row from an FWFT FIFO, zero-padding each row to ROW_SLOTS slots.
// Latency: pop is combinational from state/empty; data_out/data_valid/row_last one cycle after the slot decision; done one cycle after the last word.
// Backpressure: an empty FIFO stalls POP (or, with `define MPS_UNDERFLOW_ABORT_EN, aborts to IDLE with error); PAD never stalls.
module matrix_pop_sequencer #(
  parameter int WORD_LENGTH = 8,
  parameter int ROW_SLOTS   = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,          // asynchronous, active-low
  input  logic                   start_i,
  input  logic                   empty_i,
  input  logic [WORD_LENGTH-1:0] matrix_length_i,
  input  logic [WORD_LENGTH-1:0] row_count_i,
  input  logic [WORD_LENGTH-1:0] fifo_data_i,
  output logic                   pop_o,
  output logic [WORD_LENGTH-1:0] data_out_o,
  output logic                   data_valid_o,
  output logic                   row_last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    POP  = 3'd2,
    PAD  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Comparisons are done one bit wider so that L=0 or R=0 cannot alias to the all-ones value.
  localparam logic [WORD_LENGTH:0] SLOTS_X   = (WORD_LENGTH+1)'(ROW_SLOTS);
  localparam logic [WORD_LENGTH:0] SLOT_LAST = (WORD_LENGTH+1)'(ROW_SLOTS - 1);
  localparam logic [WORD_LENGTH:0] ONE_X     = (WORD_LENGTH+1)'(1);

  state_t                 state_q;
  logic [WORD_LENGTH-1:0] slot_q;      // S: slot index within the current row
  logic [WORD_LENGTH-1:0] row_q;       // K: current row index
  logic [WORD_LENGTH-1:0] len_q;       // L: real words per row
  logic [WORD_LENGTH-1:0] rows_q;      // R: rows per matrix
  logic [WORD_LENGTH-1:0] data_q;
  logic                   valid_q;
  logic                   last_q;
  logic                   done_q;
  logic                   error_q;

  logic [WORD_LENGTH-1:0] slot_d;
  logic [WORD_LENGTH-1:0] row_d;
  logic                   len_end_d;   // current pop is the last real word of the row
  logic                   row_end_d;   // current slot is the last slot of the row
  logic                   last_row_d;  // current row is the last row of the matrix
  logic                   pad_row_d;   // rows need zero padding (L < ROW_SLOTS)
  logic                   bad_cfg_d;   // launch-time configuration is illegal

  // Slot/row bookkeeping decoded from the registered counters and the launch-time inputs.
  always_comb begin
    slot_d     = slot_q + 1'b1;
    row_d      = row_q + 1'b1;
    len_end_d  = ({1'b0, slot_q} == ({1'b0, len_q} - ONE_X));
    row_end_d  = ({1'b0, slot_q} == SLOT_LAST);
    last_row_d = ({1'b0, row_q} == ({1'b0, rows_q} - ONE_X));
    pad_row_d  = ({1'b0, len_q} < SLOTS_X);
    bad_cfg_d  = (matrix_length_i == '0) ||
                 ({1'b0, matrix_length_i} > SLOTS_X) ||
                 (row_count_i == '0);
  end

  assign pop_o        = (state_q == POP) && !empty_i;
  assign busy_o       = (state_q != IDLE);
  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign row_last_o   = last_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

  // Sequencer FSM with registered stream outputs; valid/last/done default low every cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      slot_q  <= '0;
      row_q   <= '0;
      len_q   <= '0;
      rows_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) state_q <= ARM;
        end
        ARM: begin
          // Launch happens on the release of start.
          if (!start_i) begin
            len_q   <= matrix_length_i;
            rows_q  <= row_count_i;
            error_q <= 1'b0;
            if (bad_cfg_d) begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              slot_q  <= '0;
              row_q   <= '0;
              state_q <= POP;
            end
          end
        end
        POP: begin
          if (!empty_i) begin
            data_q  <= fifo_data_i;
            valid_q <= 1'b1;
            if (len_end_d && !pad_row_d) begin
              // L == ROW_SLOTS: the last real word closes the row.
              last_q <= 1'b1;
              slot_q <= '0;
              row_q  <= row_d;
              state_q <= last_row_d ? DONE : POP;
            end else begin
              slot_q <= slot_d;
              if (len_end_d) state_q <= PAD;
            end
          end
`ifdef MPS_UNDERFLOW_ABORT_EN
          else begin
            // Underflow aborts the matrix: no done, sticky error.
            error_q <= 1'b1;
            slot_q  <= '0;
            row_q   <= '0;
            state_q <= IDLE;
          end
`endif
        end
        PAD: begin
          data_q  <= '0;
          valid_q <= 1'b1;
          if (row_end_d) begin
            last_q <= 1'b1;
            slot_q <= '0;
            row_q  <= row_d;
            state_q <= last_row_d ? DONE : POP;
          end else begin
            slot_q <= slot_d;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_pop_sequencer.sv
// Directed bench for matrix_pop_sequencer (WORD_LENGTH=8, ROW_SLOTS=8).
// A queue stands in for the FWFT FIFO; pops are retired just after each rising edge.
// Table of transactions plus hand sequences for error stickiness and mid-run reset.
module tb_matrix_pop_sequencer;

  localparam int WL = 8;
  localparam int RS = 8;

  logic          clk_i;
  logic          reset_i;
  logic          start_i;
  logic          empty_i;
  logic [WL-1:0] matrix_length_i;
  logic [WL-1:0] row_count_i;
  logic [WL-1:0] fifo_data_i;
  logic          pop_o;
  logic [WL-1:0] data_out_o;
  logic          data_valid_o;
  logic          row_last_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;

  matrix_pop_sequencer #(.WORD_LENGTH(WL), .ROW_SLOTS(RS)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .empty_i        (empty_i),
    .matrix_length_i(matrix_length_i),
    .row_count_i    (row_count_i),
    .fifo_data_i    (fifo_data_i),
    .pop_o          (pop_o),
    .data_out_o     (data_out_o),
    .data_valid_o   (data_valid_o),
    .row_last_o     (row_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int l;
    int r;
    int base;
    int stall_after;   // pops before the FIFO is forced empty
    int stall_len;     // cycles forced empty (0 = none)
    int start_at;      // loop cycle of a stray start pulse (-1 = none)
    int exp_pops;
    int exp_err;
    int exp_done;
  } vec_t;

  logic [WL-1:0] fq[$];
  logic          force_empty;
  int            pop_total;
  int            checks;
  int            errors;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic refresh();
    empty_i     = force_empty || (fq.size() == 0);
    fifo_data_i = (fq.size() != 0) ? fq[0] : '0;
  endtask

  // One clock: sample pop before the edge, retire it after the edge.
  task automatic step();
    logic p;
    #1;
    p = pop_o;
    @(posedge clk_i);
    #1;
    if (p) begin
      void'(fq.pop_front());
      pop_total++;
    end
    refresh();
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [WL-1:0] expq[$];
    logic [WL-1:0] got[$];
    logic          lastq[$];
    int  legal, pops0, stall_cnt, done_cnt, done_cyc, first_v, last_v;
    int  mism, lmism, extra, n, finished, gap, exp_gap;
    legal = (v.l >= 1 && v.l <= RS && v.r >= 1);
    fq.delete();
    force_empty = 1'b0;
    if (legal) begin
      for (int i = 0; i < v.l * v.r; i++) fq.push_back(WL'(v.base + i));
      for (int k = 0; k < v.r; k++)
        for (int s = 0; s < RS; s++)
          expq.push_back((s < v.l) ? WL'(v.base + k * v.l + s) : WL'(0));
    end else begin
      for (int i = 0; i < 4; i++) fq.push_back(8'hAA);
    end
    exp_gap = v.stall_len;
`ifdef MPS_UNDERFLOW_ABORT_EN
    if (v.stall_len > 0) begin
      while (expq.size() > v.stall_after) void'(expq.pop_back());
      exp_gap = 0;
    end
`endif
    refresh();
    matrix_length_i = WL'(v.l);
    row_count_i     = WL'(v.r);
    pops0 = pop_total;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    check({tag, "_busy_launch"}, busy_o, legal);
    check({tag, "_err_launch"}, error_o, !legal);
    stall_cnt = 0; done_cnt = 0; done_cyc = -1; first_v = -1; last_v = -1;
    finished = 0;
    for (n = 0; n < 400; n++) begin
      if (v.stall_len > 0 && (pop_total - pops0) == v.stall_after && stall_cnt < v.stall_len) begin
        force_empty = 1'b1;
        stall_cnt++;
      end else begin
        force_empty = 1'b0;
      end
      start_i = (n == v.start_at);
      refresh();
      step();
      if (data_valid_o) begin
        got.push_back(data_out_o);
        lastq.push_back(row_last_o);
        if (first_v < 0) first_v = n;
        last_v = n;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = n;
      end
      if (!busy_o) begin
        finished = 1;
        break;
      end
    end
    start_i = 1'b0;
    force_empty = 1'b0;
    refresh();
    check({tag, "_finished"}, finished, 1);
    extra = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (done_o || data_valid_o) extra++;
    end
    check({tag, "_tail_quiet"}, extra, 0);
    check({tag, "_pops"}, pop_total - pops0, v.exp_pops);
    check({tag, "_words"}, got.size(), expq.size());
    mism = 0; lmism = 0;
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      if (got[i] !== expq[i]) mism++;
      if (lastq[i] !== ((i % RS) == RS - 1)) lmism++;
    end
    check({tag, "_data_mismatches"}, mism, 0);
    check({tag, "_rowlast_mismatches"}, lmism, 0);
    check({tag, "_done_count"}, done_cnt, v.exp_done);
    if (v.exp_done != 0) check({tag, "_done_timing"}, done_cyc, last_v + 1);
    gap = (first_v < 0) ? 0 : (last_v - first_v + 1) - got.size();
    check({tag, "_stall_gap"}, gap, exp_gap);
    check({tag, "_err_end"}, error_o, v.exp_err);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;
    int   abort;
    int   ok;
    checks = 0; errors = 0; pop_total = 0;
`ifdef MPS_UNDERFLOW_ABORT_EN
    abort = 1;
`else
    abort = 0;
`endif
    //        l  r  base sa sl start pops err done
    vecs[0] = '{8, 1,   1, 0, 0, -1,  8, 0, 1};
    vecs[1] = '{3, 2,  10, 0, 0, -1,  6, 0, 1};
    vecs[2] = '{4, 1,   1, 2, 3, -1,  4, 0, 1};
    vecs[3] = '{0, 1,   1, 0, 0, -1,  0, 1, 0};
    vecs[4] = '{9, 1,   1, 0, 0, -1,  0, 1, 0};
    vecs[5] = '{2, 0,   1, 0, 0, -1,  0, 1, 0};
    vecs[6] = '{5, 2,  40, 0, 0,  3, 10, 0, 1};
    vecs[7] = '{7, 3, 100, 0, 0, -1, 21, 0, 1};
    if (abort != 0) begin
      vecs[2].exp_pops = 2;
      vecs[2].exp_err  = 1;
      vecs[2].exp_done = 0;
    end

    reset_i = 1'b0;
    start_i = 1'b0;
    force_empty = 1'b0;
    matrix_length_i = '0;
    row_count_i = '0;
    refresh();
    #12;
    check("reset_outputs",
          {pop_o, data_out_o, data_valid_o, row_last_o, busy_o, done_o, error_o}, 0);
    reset_i = 1'b1;
    step();
    check("idle_busy", busy_o, 0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Error stays set while idle after an illegal launch.
    v = '{0, 2, 1, 0, 0, -1, 0, 1, 0};
    run_txn(v, "sticky");
    for (int i = 0; i < 3; i++) step();
    check("err_sticky_idle", error_o, 1);

    // Reset in row 2 of a 5x3 matrix, then a clean rerun.
    fq.delete();
    for (int i = 0; i < 15; i++) fq.push_back(WL'(60 + i));
    refresh();
    matrix_length_i = 8'd5;
    row_count_i = 8'd3;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pop_total >= 0 && fq.size() <= 8) begin
        ok = 1;
        break;
      end
    end
    check("rst_reached_row2", ok, 1);
    check("rst_busy_before", busy_o, 1);
    #1;
    reset_i = 1'b0;
    #1;
    check("rst_outputs_zero",
          {pop_o, data_out_o, data_valid_o, row_last_o, busy_o, done_o, error_o}, 0);
    #1;
    reset_i = 1'b1;
    v = '{5, 3, 60, 0, 0, -1, 15, 0, 1};
    run_txn(v, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
